// File: rtl/fp_mult_arbiter.sv
// Shared IEEE-754 single-precision multiplier arbitrated among N_REQ requesters (IDLE/MUL/RSP).
// Define FP_MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; otherwise round-robin.
module fp_mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_grant;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_result;
`ifndef FP_MULT_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     r_ptr;
`endif

    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_idx;
    logic               w_accept;
    logic               w_done;

    logic               w_sign;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [47:0]        w_prod;
    logic signed [9:0]  w_exp, w_exp_n, w_exp_f;
    logic [22:0]        w_mant;
    logic               w_guard, w_sticky;
    logic [23:0]        w_mant_r;
    logic [31:0]        w_fp_res;

    // Winner search: walk N_REQ slots starting at the pointer (or at 0 for fixed priority).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
            w_idx = IDW'(k);
`else
            w_idx = r_ptr + IDW'(k);
`endif
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Multiplier: denormals flush to zero, round to nearest even, NaN results are canonical quiet NaN.
    always_comb begin
        w_sign   = r_op_a[31] ^ r_op_b[31];
        w_a_zero = (r_op_a[30:23] == 8'h00);
        w_b_zero = (r_op_b[30:23] == 8'h00);
        w_a_inf  = (r_op_a[30:23] == 8'hff) && (r_op_a[22:0] == 23'd0);
        w_b_inf  = (r_op_b[30:23] == 8'hff) && (r_op_b[22:0] == 23'd0);
        w_a_nan  = (r_op_a[30:23] == 8'hff) && (r_op_a[22:0] != 23'd0);
        w_b_nan  = (r_op_b[30:23] == 8'hff) && (r_op_b[22:0] != 23'd0);
        w_prod   = {24'd0, 1'b1, r_op_a[22:0]} * {24'd0, 1'b1, r_op_b[22:0]};
        w_exp    = {2'b00, r_op_a[30:23]} + {2'b00, r_op_b[30:23]} - 10'd127;
        if (w_prod[47]) begin
            w_mant   = w_prod[46:24];
            w_guard  = w_prod[23];
            w_sticky = |w_prod[22:0];
            w_exp_n  = w_exp + 10'sd1;
        end else begin
            w_mant   = w_prod[45:23];
            w_guard  = w_prod[22];
            w_sticky = |w_prod[21:0];
            w_exp_n  = w_exp;
        end
        w_mant_r = {1'b0, w_mant} + {23'd0, w_guard & (w_sticky | w_mant[0])};
        w_exp_f  = w_mant_r[23] ? w_exp_n + 10'sd1 : w_exp_n;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_fp_res = 32'h7fc0_0000;
        end else if (w_a_inf || w_b_inf) begin
            w_fp_res = {w_sign, 8'hff, 23'd0};
        end else if (w_a_zero || w_b_zero) begin
            w_fp_res = {w_sign, 31'd0};
        end else if (w_exp_f >= 10'sd255) begin
            w_fp_res = {w_sign, 8'hff, 23'd0};
        end else if (w_exp_f <= 10'sd0) begin
            w_fp_res = {w_sign, 31'd0};
        end else begin
            w_fp_res = {w_sign, w_exp_f[7:0], w_mant_r[22:0]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    req_ready[w_win] = 1'b1;
                    w_accept         = 1'b1;
                    w_state_nxt      = MUL;
                end
            end
            MUL: begin
                busy        = 1'b1;
                w_state_nxt = RSP;
            end
            RSP: begin
                busy               = 1'b1;
                rsp_valid[r_grant] = 1'b1;
                if (rsp_ready[r_grant]) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Reset is synchronous, so outputs are masked while rst_n is low.
        if (!rst_n) begin
            req_ready = '0;
            rsp_valid = '0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
`ifndef FP_MULT_ARB_FIXED_PRIO_EN
            r_ptr    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_a  <= req_a[w_win*32 +: 32];
                r_op_b  <= req_b[w_win*32 +: 32];
                r_grant <= w_win;
`ifndef FP_MULT_ARB_FIXED_PRIO_EN
                r_ptr   <= w_win + IDW'(1);
`endif
            end
            if (r_state == MUL) begin
                r_result <= w_fp_res;
            end
            // Result bus returns to its idle value once the owner takes the product.
            if (w_done) begin
                r_result <= '0;
            end
        end
    end

    assign rsp_result = r_result;
    assign grant_id   = r_grant;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter: directed scenarios plus randomized operands
// checked against an arithmetic FP32 multiply model and a round-robin/priority grant model.
module tb_fp_mult_arbiter;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    localparam int WRAP_G0 = 0;
    localparam int WRAP_G1 = 3;
`else
    localparam int WRAP_G0 = 3;
    localparam int WRAP_G1 = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [31:0]       rsp_result;
    logic              busy;
    logic [IW-1:0]     grant_id;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    fp_mult_arbiter #(.N_REQ(N), .IDW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference multiply from the value definition: exact integer product, then round to 24 bits.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, prod, q, rem, half;
        int ea, eb, e, sh;
        logic s;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7fc00000;
        if (a_inf || b_inf) return {s, 8'hff, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        ma   = 64'(1 << 23) + 64'(a[22:0]);
        mb   = 64'(1 << 23) + 64'(b[22:0]);
        prod = ma * mb;
        e    = ea + eb - 127;
        sh   = 23;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(q - (64'd1 << 23))};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = int'($urandom_range(0, 15));
        if (k == 0) v[30:23] = 8'h00;
        else if (k == 1) v[30:0] = {8'hff, 23'd0};
        else if (k == 2) v[30:23] = 8'($urandom_range(1, 254));
        else v[30:23] = 8'($urandom_range(64, 190));
        return v;
    endfunction

    function automatic int exp_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
            if (v[k]) return k;
`else
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        end
        return -1;
    endfunction

    // One transaction from the IDLE cycle through response handshake; returns at accept-free posedge+1.
    task automatic issue(input int stall, input bit drop, output int g, output logic [31:0] res,
                         output longint t_acc);
        logic [31:0] a, b, er;
        int cyc;
        g = exp_winner(req_valid);
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'(1 << g));
        chk("idle_busy", 32'(busy), 32'd0);
        a  = req_a[g*32 +: 32];
        b  = req_b[g*32 +: 32];
        er = fmul_ref(a, b);
        @(posedge clk);
        t_acc = longint'($time);
        #1;
        m_ptr = (g + 1) % N;
        if (drop) req_valid[g] = 1'b0;
        req_a[g*32 +: 32] = rnd_fp();
        req_b[g*32 +: 32] = rnd_fp();
        rsp_ready = (stall > 0) ? ~(N'(1) << g) : '1;
        @(negedge clk);
        chk("mul_busy", 32'(busy), 32'd1);
        chk("mul_req_ready", 32'(req_ready), 32'd0);
        chk("mul_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("grant_id", 32'(grant_id), 32'(g));
        cyc = 0;
        while (cyc < 4) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != 0) break;
        end
        chk("latency", 32'(cyc), 32'd1);
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << g));
        chk("rsp_result", rsp_result, er);
        res = rsp_result;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            if (s == stall - 1) rsp_ready = '1;
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'(1 << g));
            chk("hold_rsp_result", rsp_result, er);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int last_g);
        req_valid = '0;
        @(negedge clk);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_busy_q", 32'(busy), 32'd0);
        chk("idle_ready_q", 32'(req_ready), 32'd0);
        chk("idle_result", rsp_result, 32'd0);
        chk("idle_grant_hold", 32'(grant_id), 32'(last_g));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    localparam logic [31:0] SA [7] = '{32'h7f800000, 32'h7f800000, 32'h00000123, 32'h7f000000,
                                       32'h3f800001, 32'h00800000, 32'h7fc00001};
    localparam logic [31:0] SB [7] = '{32'h00000000, 32'hc0000000, 32'h40000000, 32'h7f000000,
                                       32'h3f800001, 32'h00800000, 32'h3f800000};
    localparam logic [31:0] SE [7] = '{32'h7fc00000, 32'hff800000, 32'h00000000, 32'h7f800000,
                                       32'h3f800002, 32'h00000000, 32'h7fc00000};

    initial begin
        int g;
        logic [31:0] res;
        longint t, t_prev;

        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        m_ptr     = 0;

        // Single operation: 2.0 * 3.0
        req_a[31:0] = 32'h40000000;
        req_b[31:0] = 32'h40400000;
        req_valid   = 4'b0001;
        issue(0, 1'b1, g, res, t);
        chk("single_grant", 32'(g), 32'd0);
        chk("single_result", res, 32'h40C00000);
        check_idle(0);

        // Special operands and rounding/range boundaries on requester 1
        for (int i = 0; i < 7; i++) begin
            req_a[63:32] = SA[i];
            req_b[63:32] = SB[i];
            req_valid    = 4'b0010;
            issue(0, 1'b1, g, res, t);
            chk("special_result", res, SE[i]);
        end
        check_idle(1);

        // Backpressure on requester 2; other rsp_ready bits are high and must be ignored
        req_valid = 4'b0100;
        issue(5, 1'b1, g, res, t);
        chk("bp_grant", 32'(g), 32'd2);
        check_idle(2);

        // Pointer now past requester 2: wrap from 3 back to 0
        req_valid = 4'b1001;
        issue(0, 1'b1, g, res, t);
        chk("wrap_first", 32'(g), 32'(WRAP_G0));
        issue(0, 1'b1, g, res, t);
        chk("wrap_second", 32'(g), 32'(WRAP_G1));
        check_idle(WRAP_G1);

        // Randomized masks, operands and response stalls
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                req_a[i*32 +: 32] = rnd_fp();
                req_b[i*32 +: 32] = rnd_fp();
            end
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            issue(int'($urandom_range(0, 2)), 1'b1, g, res, t);
        end
        check_idle(g);

        // Contention after reset: all requesters held valid, issue every 3 cycles
        do_reset();
        req_valid = '1;
        t_prev    = 0;
        for (int i = 0; i < 5; i++) begin
            issue(0, 1'b0, g, res, t);
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
            chk("contention_grant", 32'(g), 32'd0);
`else
            chk("contention_grant", 32'(g), 32'(i % N));
`endif
            if (i > 0) chk("issue_interval", 32'(t - t_prev), 32'd30);
            t_prev = t;
        end
        check_idle(g);

        // Reset while the response is pending must drop it
        req_a[63:32] = 32'h40000000;
        req_b[63:32] = 32'h40000000;
        req_valid    = 4'b0010;
        rsp_ready    = '0;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'b0010);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("in_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("in_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_ptr     = 0;
        rsp_ready = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_result", rsp_result, 32'd0);
            chk("post_rst_grant", 32'(grant_id), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = '1;
        issue(0, 1'b1, g, res, t);
        chk("post_rst_first_grant", 32'(g), 32'd0);
        check_idle(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
